// File: rtl/mb_scheduler.sv
// mb_scheduler: raster-order macroblock scheduler pacing the extractor and intra-prediction handshake.
// Optional feature: define MB_SCHED_STALL_CNT_EN to add a saturating stall_cnt output.
module mb_scheduler #(
  parameter int WIDTH       = 720,
  parameter int LENGTH      = 1280,
  parameter int MB_SIZE_L   = 16,
  parameter int MB_SIZE_W   = 16,
  parameter int EXTRACT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ext_enable,
  output logic [12:0] mbnumber,
  output logic        mb_valid,
  input  logic        mb_ready,
  output logic        top_avail,
  output logic        left_avail,
  output logic        busy,
`ifdef MB_SCHED_STALL_CNT_EN
  output logic        frame_done,
  output logic [15:0] stall_cnt
`else
  output logic        frame_done
`endif
);

  localparam int MB_COLS  = LENGTH / MB_SIZE_W;
  localparam int MB_ROWS  = WIDTH / MB_SIZE_L;
  localparam int MB_TOTAL = MB_COLS * MB_ROWS;
  localparam int CNT_W    = $clog2(EXTRACT_LAT + 1);

  localparam logic [12:0]      LAST_MB  = 13'(MB_TOTAL - 1);
  localparam logic [12:0]      LAST_COL = 13'(MB_COLS - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(EXTRACT_LAT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] VALID = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [12:0]      mb_x;
  logic [12:0]      mb_y;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mbnumber <= '0;
      mb_x     <= '0;
      mb_y     <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            mbnumber <= '0;
            mb_x     <= '0;
            mb_y     <= '0;
          end
        end
        FETCH: begin
          state    <= WAIT;
          wait_cnt <= LAT_LOAD;
        end
        WAIT: begin
          // Leaving on a count of 1 keeps WAIT exactly EXTRACT_LAT cycles long.
          if (wait_cnt <= CNT_W'(1)) begin
            state    <= VALID;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        VALID: begin
          if (mb_ready) begin
            if (mbnumber == LAST_MB) begin
              state <= DONE;
            end else begin
              state    <= FETCH;
              mbnumber <= mbnumber + 13'd1;
              if (mb_x == LAST_COL) begin
                mb_x <= '0;
                mb_y <= mb_y + 13'd1;
              end else begin
                mb_x <= mb_x + 13'd1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ext_enable = (state == FETCH);
  assign mb_valid   = (state == VALID);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign top_avail  = (mb_y != '0);
  assign left_avail = (mb_x != '0);

`ifdef MB_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (mb_valid && !mb_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
